// File: rtl/execute_mc.sv
// execute_mc: multi-cycle execute unit with a valid/ready handshake.
// Single-cycle ALU ops complete in one cycle. MUL/MULHU use an iterative
// shift-add unit. DIVU/REMU use a restoring divider that is present only
// when EXECUTE_MC_DIV_EN is defined; otherwise those ops are illegal.
//
// state | meaning
// IDLE  | no op in flight, ready to accept
// BUSY  | iterating a multi-cycle op, counter running down
// DONE  | result/flags/illegal presented with out_valid=1
module execute_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       fl,
  output logic             illegal,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [4:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [1:0]         fl_q, fl_d;
  logic               illegal_q, illegal_d;
`ifdef EXECUTE_MC_DIV_EN
  logic [WIDTH-1:0]   b_q, b_d;
`endif

  logic               accept;
  logic               is_multi;
  logic               wr;
  logic [SW-1:0]      sh;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_ill;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] step_next;
  logic [WIDTH-1:0]   busy_res;
`ifdef EXECUTE_MC_DIV_EN
  logic [WIDTH:0]     div_sh;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
`endif

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready & ~flush;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign result    = result_q;
  assign fl        = fl_q;
  assign illegal   = illegal_q;
  assign sh        = b[SW-1:0];

  // Classify the incoming op: which ones take the iterative path.
  always_comb begin
    is_multi = 1'b0;
    case (op)
      5'd16, 5'd17: is_multi = 1'b1;
`ifdef EXECUTE_MC_DIV_EN
      5'd18, 5'd19: is_multi = 1'b1;
`endif
      default:      is_multi = 1'b0;
    endcase
  end

  // Single-cycle ALU result; anything unsupported yields 0 and illegal.
  always_comb begin
    sc_res = '0;
    sc_ill = 1'b0;
    case (op)
      5'd0:    sc_res = a + b;
      5'd1:    sc_res = a - b;
      5'd2:    sc_res = a & b;
      5'd3:    sc_res = a | b;
      5'd4:    sc_res = a ^ b;
      5'd5:    sc_res = ~a;
      5'd6:    sc_res = a << sh;
      5'd7:    sc_res = a >> sh;
      5'd8:    sc_res = $unsigned($signed(a) >>> sh);
      5'd9:    sc_res = b;
      default: sc_ill = 1'b1;
    endcase
  end

  // One iteration of the multi-cycle datapath, selected by the latched op.
  // Multiply: hi half accumulates a, whole accumulator shifts right.
  // Divide: hi half is the partial remainder, lo half shifts quotient in.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef EXECUTE_MC_DIV_EN
    div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, b_q});
    div_sub  = div_sh[WIDTH-1:0] - b_q;
    div_next = div_ge ? {div_sub, acc_q[WIDTH-2:0], 1'b1}
                      : {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
`endif
    step_next = mul_next;
    busy_res  = mul_next[WIDTH-1:0];
    case (op_q)
      5'd17: busy_res = mul_next[2*WIDTH-1:WIDTH];
`ifdef EXECUTE_MC_DIV_EN
      5'd18: begin
        step_next = div_next;
        busy_res  = div_next[WIDTH-1:0];
      end
      5'd19: begin
        step_next = div_next;
        busy_res  = div_next[2*WIDTH-1:WIDTH];
      end
`endif
      default: busy_res = mul_next[WIDTH-1:0];
    endcase
  end

  // Next-state, counter and output-register logic; flush overrides all.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    op_d      = op_q;
    a_d       = a_q;
    result_d  = result_q;
    fl_d      = fl_q;
    illegal_d = illegal_q;
    wr        = 1'b0;
`ifdef EXECUTE_MC_DIV_EN
    b_d       = b_q;
`endif
    case (state_q)
      BUSY: begin
        acc_d = step_next;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d  = busy_res;
          illegal_d = 1'b0;
          wr        = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = state_q;
    endcase
    if (accept) begin
      op_d = op;
      a_d  = a;
`ifdef EXECUTE_MC_DIV_EN
      b_d  = b;
`endif
      if (is_multi) begin
        state_d = BUSY;
        cnt_d   = CNT_LOAD;
        if (op[1]) acc_d = {{WIDTH{1'b0}}, a};
        else       acc_d = {{WIDTH{1'b0}}, b};
      end else begin
        state_d   = DONE;
        result_d  = sc_res;
        illegal_d = sc_ill;
        wr        = 1'b1;
      end
    end
    if (wr) fl_d = {result_d[WIDTH-1], (result_d == '0)};
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      result_q  <= '0;
      fl_q      <= 2'b00;
      illegal_q <= 1'b0;
`ifdef EXECUTE_MC_DIV_EN
      b_q       <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      op_q      <= op_d;
      a_q       <= a_d;
      result_q  <= result_d;
      fl_q      <= fl_d;
      illegal_q <= illegal_d;
`ifdef EXECUTE_MC_DIV_EN
      b_q       <= b_d;
`endif
    end
  end

endmodule

// File: tb/tb_execute_mc.sv
// tb_execute_mc: directed vectors for execute_mc (WIDTH=32) with a
// scoreboard queue filled at accept and drained by a separate monitor.
module tb_execute_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [1:0]  fl;
  logic        illegal;
  logic        busy;

  execute_mc #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .fl        (fl),
    .illegal   (illegal),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic [1:0]  f;
    logic        il;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   next_id = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] fl_of(input logic [31:0] r);
    return {r[31], (r == 32'd0)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  // Monitor: every handshaken output must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output got r=%h fl=%b il=%b", result, fl, illegal);
      end else begin
        mon_e = sb.pop_front();
        pop_cyc.push_back(cyc);
        if (result !== mon_e.r || fl !== mon_e.f || illegal !== mon_e.il) begin
          bad++;
          $display("FAIL sb_item%0d got r=%h fl=%b il=%b want r=%h fl=%b il=%b",
                   mon_e.id, result, fl, illegal, mon_e.r, mon_e.f, mon_e.il);
        end
      end
    end
  end

  // Present an op, wait (bounded) for acceptance, record the expectation.
  // Called and returns at posedge+1.
  task automatic send(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] er, input logic ei, input logic push);
    bit done;
    exp_t e;
    done = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        @(posedge clk);
        if (push) begin
          e.r = er; e.f = fl_of(er); e.il = ei; e.id = next_id;
          next_id++;
          sb.push_back(e);
        end
        done = 1;
      end else begin
        @(posedge clk);
      end
    end
    #1;
    in_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL accept_timeout op=%0d in_ready=%b want accept", o, in_ready);
    end
  endtask

  task automatic wait_drain(input string nm);
    bit done;
    done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (sb.size() == 0) done = 1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s drain_timeout pending=%0d want 0", nm, sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  int busy_cnt;
  int ov_at;
  int ov_cnt;
  int n0;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_fl", {30'd0, fl}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // ADD wrapping to zero, one-cycle latency
    send(5'd0, 32'd5, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("add_latency_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;

    // SUB held under backpressure
    out_ready = 1'b0;
    send(5'd1, 32'd1, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_result", result, 32'hFFFF_FFFF);
      chk("hold_fl", {30'd0, fl}, 32'd2);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    wait_drain("sub_hold");

    // MUL latency and busy window
    send(5'd16, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b1);
    busy_cnt = 0; ov_at = 0;
    for (int i = 1; i <= 40 && ov_at == 0; i++) begin
      @(negedge clk);
      if (out_valid) ov_at = i;
      else if (busy) busy_cnt++;
    end
    chk("mul_busy_cycles", busy_cnt, 32'd32);
    chk("mul_out_valid_at", ov_at, 32'd33);
    wait_drain("mul");
    send(5'd17, 32'h0001_0000, 32'h0001_0000, 32'd1, 1'b0, 1'b1);
    wait_drain("mulhu");
    send(5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
    wait_drain("mul_ff");
    send(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1);
    wait_drain("mulhu_ff");
    send(5'd17, 32'h0000_1234, 32'h0000_0010, 32'd0, 1'b0, 1'b1);
    wait_drain("mulhu_small");

`ifdef EXECUTE_MC_DIV_EN
    send(5'd18, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1);
    wait_drain("divu");
    send(5'd19, 32'd100, 32'd7, 32'd2, 1'b0, 1'b1);
    wait_drain("remu");
    send(5'd18, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    wait_drain("divu_zero");
    send(5'd19, 32'd9, 32'd0, 32'd9, 1'b0, 1'b1);
    wait_drain("remu_zero");
`else
    send(5'd18, 32'd100, 32'd7, 32'd0, 1'b1, 1'b1);
    @(negedge clk);
    chk("divu_single_cycle", {31'd0, out_valid}, 32'd1);
    wait_drain("divu_off");
    send(5'd19, 32'd100, 32'd7, 32'd0, 1'b1, 1'b1);
    wait_drain("remu_off");
`endif

    // Logic, shift and pass ops
    send(5'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b1);
    send(5'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b1);
    send(5'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b1);
    send(5'd5, 32'h0000_FFFF, 32'd0, 32'hFFFF_0000, 1'b0, 1'b1);
    send(5'd6, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1'b1);
    send(5'd7, 32'h8000_0000, 32'h21, 32'h4000_0000, 1'b0, 1'b1);
    send(5'd9, 32'd0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
    send(5'd8, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b1);
    wait_drain("logic_ops");

    // Reset in the middle of a MUL: op is lost, reset values return
    send(5'd16, 32'd3, 32'd4, 32'd12, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_result", result, 32'd0);
    chk("midrst_fl", {30'd0, fl}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Illegal opcodes
    send(5'd12, 32'd7, 32'd9, 32'd0, 1'b1, 1'b1);
    send(5'd10, 32'd7, 32'd9, 32'd0, 1'b1, 1'b1);
    send(5'd15, 32'd7, 32'd9, 32'd0, 1'b1, 1'b1);
    send(5'd20, 32'd7, 32'd9, 32'd0, 1'b1, 1'b1);
    send(5'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b1);
    wait_drain("illegal_ops");

    // Flush at cycle N+10 of a MUL
    send(5'd16, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    ov_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) ov_cnt++;
    end
    chk("flush_no_out_valid", ov_cnt, 32'd0);
    @(posedge clk); #1;
    send(5'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b1);
    wait_drain("post_flush_add");

    // Streaming 8 ADDs back to back
    n0 = pop_cyc.size();
    for (int i = 0; i < 8; i++)
      send(5'd0, i, 32'd100, 32'd100 + i, 1'b0, 1'b1);
    wait_drain("stream");
    chk("stream_count", pop_cyc.size() - n0, 32'd8);
    if (pop_cyc.size() - n0 == 8)
      chk("stream_consecutive", pop_cyc[n0 + 7] - pop_cyc[n0], 32'd7);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout time=%0t want finish", $time);
    $fatal(1, "timeout");
  end

endmodule
